// File: rtl/clock_pkg.sv
// Shared encodings for the CPU clock sequencer.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_STEP  = 2'b01,
    MODE_BURST = 2'b10
  } mode_e;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_e;

endpackage

// File: rtl/clock_sequencer_if.sv
// Control/status bundle between the sequencer and its surroundings.
interface clock_sequencer_if #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned BURST_WIDTH = 8
);
  logic [DIV_WIDTH-1:0]   div;
  logic [1:0]             mode;
  logic                   step;
  logic [BURST_WIDTH-1:0] burst_len;
  logic                   burst_go;
  logic                   hlt;
  logic                   clk_out;
  logic                   clk_en;
  logic                   busy;
  logic                   halted;

  modport master (
    output div, mode, step, burst_len, burst_go, hlt,
    input  clk_out, clk_en, busy, halted
  );

  modport slave (
    input  div, mode, step, burst_len, burst_go, hlt,
    output clk_out, clk_en, busy, halted
  );
endinterface

// File: rtl/clock_sequencer_debouncer.sv
// Step button conditioning: 2-flop synchroniser, stability debouncer and
// rising-edge pulse of the debounced level.
module step_debouncer #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk_base,
  input  logic rst,
  input  logic in_raw,
  output logic out_level,
  output logic out_rise
);
  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;

  // Count consecutive cycles the synchronised input differs from the level;
  // flip the level on the DEB_CYCLES-th one, restart on any agreement.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser, debounce state and registered edge pulse.
  always_ff @(posedge clk_base) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], in_raw};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign out_level = level_q;
  assign out_rise  = rise_q;
endmodule

// File: rtl/clock_sequencer.sv
// CPU clock generator: programmable-divisor LOW/HIGH phase FSM gated by
// run / debounced single-step / counted-burst modes and a halt input.
module clock_sequencer
  import clock_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned BURST_WIDTH = 8,
  parameter int unsigned DEB_CYCLES  = 16
) (
  input  logic             clk_base,
  input  logic             rst,
  clock_sequencer_if.slave bus
);
  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [DIV_WIDTH-1:0]   div_eff;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic                   token_q, token_d;
  logic                   clk_out_q, clk_out_d;
  logic                   clk_en_q, clk_en_d;
  logic                   halted_q, halted_d;
  logic                   mode_run, mode_step, mode_burst;
  logic                   phase_done, permit, rise_go;
  logic                   step_level, step_rise, step_press;

  step_debouncer #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk_base (clk_base),
    .rst      (rst),
    .in_raw   (bus.step),
    .out_level(step_level),
    .out_rise (step_rise)
  );

  // The pulse only ever accompanies a freshly raised level.
  assign step_press = step_rise && step_level;

  assign mode_run   = (bus.mode == MODE_RUN);
  assign mode_burst = (bus.mode == MODE_BURST);
  assign mode_step  = !mode_run && !mode_burst;

  assign div_eff    = (bus.div == '0) ? DIV_WIDTH'(1) : bus.div;
  assign phase_done = (cnt_q == div_q - DIV_WIDTH'(1));
  assign permit     = !bus.hlt && (mode_run ||
                                   (mode_step && token_q) ||
                                   (mode_burst && burst_q != '0));
  assign rise_go    = (state_q == ST_LOW) && phase_done && permit;

  // Phase state register.
  always_ff @(posedge clk_base) begin
    if (rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      div_q   <= DIV_WIDTH'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  // Next phase: HIGH always runs to completion; LOW holds once done until permitted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    unique case (state_q)
      ST_LOW: begin
        if (!phase_done) begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end else if (permit) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          div_d   = div_eff;
        end
      end
      ST_HIGH: begin
        if (phase_done) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          div_d   = div_eff;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  // Output decode, registered below so clk_out stays glitch-free.
  always_comb begin
    clk_out_d = (state_d == ST_HIGH);
    clk_en_d  = rise_go;
    halted_d  = (state_q == ST_LOW) && phase_done && bus.hlt;
  end

  // Registered outputs.
  always_ff @(posedge clk_base) begin
    if (rst) begin
      clk_out_q <= 1'b0;
      clk_en_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      clk_out_q <= clk_out_d;
      clk_en_q  <= clk_en_d;
      halted_q  <= halted_d;
    end
  end

  // Step token and burst counter; each is consumed by the rising transition.
  always_comb begin
    token_d = token_q;
    burst_d = burst_q;
    if (!mode_step) begin
      token_d = 1'b0;
    end else if (rise_go) begin
      token_d = 1'b0;
    end else if (step_press) begin
      token_d = 1'b1;
    end
    if (!mode_burst) begin
      burst_d = '0;
    end else if (burst_q == '0) begin
      if (bus.burst_go) begin
        burst_d = bus.burst_len;
      end
    end else if (rise_go) begin
      burst_d = burst_q - BURST_WIDTH'(1);
    end
  end

  // Token and burst registers.
  always_ff @(posedge clk_base) begin
    if (rst) begin
      token_q <= 1'b0;
      burst_q <= '0;
    end else begin
      token_q <= token_d;
      burst_q <= burst_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.clk_en  = clk_en_q;
  assign bus.busy    = (burst_q != '0);
  assign bus.halted  = halted_q;
endmodule
